// File: rtl/if_fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared types for the RV32 instruction fetch stage: PC/instruction words,
//   register address fields, the fetch queue entry and the IF/ID load select.
//   No ports (package).
// ----------------------------------------------------------------------------
package if_fetch_stage_pkg;

   typedef logic [31:0] pc_t;
   typedef logic [31:0] instr_t;
   typedef logic [4:0]  reg_addr_t;

   // addi x0, x0, 0
   localparam instr_t RV32_NOP = 32'h0000_0013;

   typedef struct packed {
      pc_t    pc;
      instr_t instr;
      logic   fault;
      logic   filled;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IFID_CLEAR,
      IFID_HOLD,
      IFID_LOAD
   } ifid_sel_e;

   function automatic reg_addr_t instr_rs1(input instr_t i);
      return i[19:15];
   endfunction

   function automatic reg_addr_t instr_rs2(input instr_t i);
      return i[24:20];
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction memory channel: valid/ready word request plus a valid-only,
//   in-order response.
//   master : fetch stage  (drives imem_req_valid, imem_req_addr)
//   slave  : memory       (drives imem_req_ready, imem_rsp_valid/data/err)
// ----------------------------------------------------------------------------
interface if_fetch_stage_if;
   import if_fetch_stage_pkg::*;

   logic   imem_req_valid;
   logic   imem_req_ready;
   pc_t    imem_req_addr;
   logic   imem_rsp_valid;
   instr_t imem_rsp_data;
   logic   imem_rsp_err;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      input  imem_rsp_err
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      output imem_rsp_err
   );

endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   In-order circular queue of fetch entries. Entries are allocated at issue
//   (unfilled), filled in order as responses return, and popped from the head.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     i_flush             discard every entry (wins over all other ops)
//     i_alloc/i_alloc_pc  allocate tail entry for a newly accepted request
//     i_fill/...          fill the oldest unfilled entry
//     i_pop               remove head entry
//     o_count             allocated entries (filled + unfilled)
//     o_unfilled          allocated entries still awaiting a response
//     o_head              head entry (meaningful only when o_count != 0)
// ----------------------------------------------------------------------------
module fetch_queue
   import if_fetch_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_alloc,
   input  pc_t                      i_alloc_pc,
   input  logic                     i_fill,
   input  instr_t                   i_fill_instr,
   input  logic                     i_fill_fault,
   input  logic                     i_pop,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [$clog2(DEPTH):0]   o_unfilled,
   output fetch_entry_t             o_head
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t r_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] r_head;
   logic [AW:0] r_tail;
   logic [AW:0] r_fptr;

   logic [AW-1:0] w_head_idx;
   logic [AW-1:0] w_tail_idx;
   logic [AW-1:0] w_fill_idx;

   assign w_head_idx = r_head[AW-1:0];
   assign w_tail_idx = r_tail[AW-1:0];
   assign w_fill_idx = r_fptr[AW-1:0];

   assign o_count    = r_tail - r_head;
   assign o_unfilled = r_tail - r_fptr;
   assign o_head     = r_mem[w_head_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_fptr <= '0;
      end else if (i_flush) begin
         r_head <= '0;
         r_tail <= '0;
         r_fptr <= '0;
      end else begin
         if (i_alloc) begin
            r_mem[w_tail_idx] <= '{pc: i_alloc_pc, instr: RV32_NOP, fault: 1'b0, filled: 1'b0};
            r_tail            <= r_tail + 1'b1;
         end
         // A fill never targets the slot allocated this cycle: responses
         // only ever answer requests accepted on an earlier edge.
         if (i_fill) begin
            r_mem[w_fill_idx].instr  <= i_fill_instr;
            r_mem[w_fill_idx].fault  <= i_fill_fault;
            r_mem[w_fill_idx].filled <= 1'b1;
            r_fptr                   <= r_fptr + 1'b1;
         end
         if (i_pop) begin
            r_head <= r_head + 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   RV32 instruction fetch stage. Owns the PC, issues word fetches over the
//   imem channel, buffers in-order responses in fetch_queue and drives the
//   IF/ID pipeline register (including rs1/rs2 for the hazard unit).
//   Parameters: RESET_PC, QUEUE_DEPTH (power of 2, >= 2).
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     pc_stall                   block new fetch issue
//     if_id_stall                hold IF/ID register
//     if_id_bubble               load NOP into IF/ID
//     branch_taken/target        redirect from EX (target[1:0] ignored)
//     imem                       instruction memory channel (master side)
//     if_id_valid/pc/instr/fault IF/ID register contents
//     if_id_rs1/rs2              instr[19:15] / instr[24:20]
//   Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt,
//   perf_squash_cnt and perf_stall_cnt outputs.
// ----------------------------------------------------------------------------
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter pc_t         RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_stall,
   input  logic                  if_id_stall,
   input  logic                  if_id_bubble,
   input  logic                  branch_taken,
   input  pc_t                   branch_target,
   if_fetch_stage_if.master      imem,
   output logic                  if_id_valid,
   output pc_t                   if_id_pc,
   output instr_t                if_id_instr,
   output logic                  if_id_fault,
   output reg_addr_t             if_id_rs1,
   output reg_addr_t             if_id_rs2
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_squash_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   localparam int unsigned AW = $clog2(QUEUE_DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(QUEUE_DEPTH);

   pc_t          r_pc_q;
   logic [AW:0]  r_drop_cnt;
   logic         r_req_pend;

   logic [AW:0]  w_count;
   logic [AW:0]  w_unfilled;
   fetch_entry_t w_head;
   logic [AW+1:0] w_inflight;
   logic         w_credit;
   logic         w_req_valid;
   logic         w_accept;
   logic         w_rsp_drop;
   logic         w_rsp_fill;
   instr_t       w_rsp_instr;
   logic         w_head_ready;
   logic         w_pop;
   instr_t       w_load_instr;
   logic         w_load_fault;
   ifid_sel_e    w_sel;

   // ---------------------------------------------------------------- issue
   // Every queued entry plus every response still to be dropped holds a slot.
   assign w_inflight = (AW+2)'(w_count) + (AW+2)'(r_drop_cnt);
   assign w_credit   = w_inflight < DEPTH_W;

   // A request left waiting for ready stays up (same address) until it is
   // accepted; pc_stall only blocks fresh issue, redirect always withdraws.
   assign w_req_valid = rst_n && !branch_taken && (r_req_pend || (!pc_stall && w_credit));
   assign w_accept    = w_req_valid && imem.imem_req_ready;

   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_req_addr  = r_pc_q;

   // ------------------------------------------------------------- response
   assign w_rsp_drop  = imem.imem_rsp_valid && (r_drop_cnt != '0);
   assign w_rsp_fill  = imem.imem_rsp_valid && (r_drop_cnt == '0);
   assign w_rsp_instr = imem.imem_rsp_err ? RV32_NOP : imem.imem_rsp_data;

   // Fills are in order, so an unfilled head is exactly the entry the
   // current response fills; that enables the same-edge bypass into IF/ID.
   assign w_head_ready = (w_count != '0) && (w_head.filled || w_rsp_fill);
   assign w_load_instr = w_head.filled ? w_head.instr : w_rsp_instr;
   assign w_load_fault = w_head.filled ? w_head.fault : imem.imem_rsp_err;

   always_comb begin
      w_sel = IFID_CLEAR;
      if (branch_taken || if_id_bubble) begin
         w_sel = IFID_CLEAR;
      end else if (if_id_stall) begin
         w_sel = IFID_HOLD;
      end else if (w_head_ready) begin
         w_sel = IFID_LOAD;
      end
   end

   assign w_pop = (w_sel == IFID_LOAD);

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fetch_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (branch_taken),
      .i_alloc      (w_accept),
      .i_alloc_pc   (r_pc_q),
      .i_fill       (w_rsp_fill),
      .i_fill_instr (w_rsp_instr),
      .i_fill_fault (imem.imem_rsp_err),
      .i_pop        (w_pop),
      .o_count      (w_count),
      .o_unfilled   (w_unfilled),
      .o_head       (w_head)
   );

   // ------------------------------------------------------ PC / drop state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc_q     <= RESET_PC;
         r_drop_cnt <= '0;
         r_req_pend <= 1'b0;
      end else begin
         if (branch_taken) begin
            r_pc_q     <= {branch_target[31:2], 2'b00};
            r_req_pend <= 1'b0;
            // Still-outstanding responses after redirect: pending drops plus
            // unfilled entries, less the one response consumed this cycle
            // (whether it was a drop or a fill the flush throws away).
            r_drop_cnt <= r_drop_cnt + w_unfilled - {{AW{1'b0}}, imem.imem_rsp_valid};
         end else begin
            if (w_accept) begin
               r_pc_q <= r_pc_q + 32'd4;
            end
            r_req_pend <= w_req_valid && !imem.imem_req_ready;
            if (w_rsp_drop) begin
               r_drop_cnt <= r_drop_cnt - 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------ IF/ID reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= RV32_NOP;
         if_id_fault <= 1'b0;
         if_id_rs1   <= '0;
         if_id_rs2   <= '0;
      end else begin
         case (w_sel)
            IFID_LOAD: begin
               if_id_valid <= 1'b1;
               if_id_pc    <= w_head.pc;
               if_id_instr <= w_load_instr;
               if_id_fault <= w_load_fault;
               if_id_rs1   <= instr_rs1(w_load_instr);
               if_id_rs2   <= instr_rs2(w_load_instr);
            end
            IFID_HOLD: begin
               if_id_valid <= if_id_valid;
               if_id_pc    <= if_id_pc;
               if_id_instr <= if_id_instr;
               if_id_fault <= if_id_fault;
               if_id_rs1   <= if_id_rs1;
               if_id_rs2   <= if_id_rs2;
            end
            default: begin
               if_id_valid <= 1'b0;
               if_id_pc    <= '0;
               if_id_instr <= RV32_NOP;
               if_id_fault <= 1'b0;
               if_id_rs1   <= instr_rs1(RV32_NOP);
               if_id_rs2   <= instr_rs2(RV32_NOP);
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // -------------------------------------------------------- perf counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch_cnt  <= '0;
         perf_squash_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         perf_fetch_cnt  <= perf_fetch_cnt + 32'(w_pop);
         perf_squash_cnt <= perf_squash_cnt + 32'(w_rsp_drop || (w_rsp_fill && branch_taken));
         perf_stall_cnt  <= perf_stall_cnt + 32'(!w_req_valid && !branch_taken);
      end
   end
`endif

   // A response with nothing outstanding is a memory protocol violation.
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      imem.imem_rsp_valid |-> ((r_drop_cnt != '0) || (w_unfilled != '0)));

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   localparam int unsigned QD = 2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_stall = 1'b0;
   logic        if_id_stall = 1'b0;
   logic        if_id_bubble = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_fault;
   logic [4:0]  if_id_rs1;
   logic [4:0]  if_id_rs2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_squash_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_stage_if imem();

   if_fetch_stage #(
      .RESET_PC    (32'h0000_0000),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_stall      (pc_stall),
      .if_id_stall   (if_id_stall),
      .if_id_bubble  (if_id_bubble),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (imem.master),
      .if_id_valid   (if_id_valid),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .if_id_fault   (if_id_fault),
      .if_id_rs1     (if_id_rs1),
      .if_id_rs2     (if_id_rs2)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_squash_cnt (perf_squash_cnt),
      .perf_stall_cnt  (perf_stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // ---------------------------------------------------- reference model
   typedef struct { logic [31:0] pc; bit live; } out_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; bit fault; } ent_t;

   out_t        m_out[$];   // requests accepted, response not yet seen
   ent_t        m_buf[$];   // responses received, waiting for IF/ID
   logic [31:0] m_pc;
   bit          m_pend;
   bit          m_v;
   logic [31:0] m_ipc, m_instr;
   bit          m_fault;
   int unsigned m_fetch, m_squash, m_stall;

   bit          s_rv;       // sampled before the edge
   logic [31:0] s_addr;

   function automatic logic [31:0] f_instr(input logic [31:0] pc);
      return (pc << 13) ^ pc ^ 32'h0000_0033;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_out.delete();
      m_buf.delete();
      m_pc = 32'h0; m_pend = 0;
      m_v = 0; m_ipc = 0; m_instr = NOP; m_fault = 0;
      m_fetch = 0; m_squash = 0; m_stall = 0;
   endtask

   task automatic check_ifid();
      logic [31:0] ins;
      ins = m_instr;
      chk("if_id_valid", 32'(if_id_valid), 32'(m_v));
      if (m_v) chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_instr", if_id_instr, ins);
      chk("if_id_fault", 32'(if_id_fault), 32'(m_fault));
      chk("if_id_rs1", 32'(if_id_rs1), 32'(ins[19:15]));
      chk("if_id_rs2", 32'(if_id_rs2), 32'(ins[24:20]));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_squash", perf_squash_cnt, m_squash);
      chk("perf_stall", perf_stall_cnt, m_stall);
`endif
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic step(input bit ps, input bit st, input bit bub, input bit br,
                       input logic [31:0] tgt, input bit rdy, input bit rsp, input bit err);
      bit mv, acc, rsp_now;
      out_t o;
      ent_t e;
      pc_stall = ps; if_id_stall = st; if_id_bubble = bub;
      branch_taken = br; branch_target = tgt;
      imem.imem_req_ready = rdy;
      rsp_now = rsp && (m_out.size() != 0);
      imem.imem_rsp_valid = rsp_now;
      imem.imem_rsp_data  = rsp_now ? f_instr(m_out[0].pc) : $urandom;
      imem.imem_rsp_err   = rsp_now && err;
      mv = !br && (m_pend || (!ps && (m_out.size() + m_buf.size() < QD)));
      #2;
      s_rv = imem.imem_req_valid;
      s_addr = imem.imem_req_addr;
      chk("req_valid", 32'(s_rv), 32'(mv));
      chk("req_addr", s_addr, m_pc);
      acc = mv && rdy;
      if (rsp_now) begin
         o = m_out.pop_front();
         if (o.live && !br) m_buf.push_back('{o.pc, err ? NOP : f_instr(o.pc), err});
         else m_squash++;
      end
      if (!br && !mv) m_stall++;
      if (br || bub) begin
         m_v = 0; m_ipc = 0; m_instr = NOP; m_fault = 0;
      end else if (!st) begin
         if (m_buf.size() != 0) begin
            e = m_buf.pop_front();
            m_v = 1; m_ipc = e.pc; m_instr = e.instr; m_fault = e.fault;
            m_fetch++;
         end else begin
            m_v = 0; m_ipc = 0; m_instr = NOP; m_fault = 0;
         end
      end
      if (br) begin
         m_buf.delete();
         foreach (m_out[i]) m_out[i].live = 0;
         m_pc = {tgt[31:2], 2'b00};
         m_pend = 0;
      end else if (acc) begin
         m_out.push_back('{m_pc, 1'b1});
         m_pc = m_pc + 32'd4;
         m_pend = 0;
      end else begin
         m_pend = mv;
      end
      @(posedge clk); #1;
      imem.imem_rsp_valid = 0;
      check_ifid();
   endtask

   task automatic idle(input bit ps, input bit st, input bit rdy, input bit rsp, input bit err);
      step(ps, st, 0, 0, 32'h0, rdy, rsp, err);
   endtask

   task automatic redirect(input logic [31:0] tgt, input bit rsp);
      step(0, 0, 0, 1, tgt, 0, rsp, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      pc_stall = 0; if_id_stall = 0; if_id_bubble = 0; branch_taken = 0;
      imem.imem_req_ready = 1; imem.imem_rsp_valid = 0;
      imem.imem_rsp_data = '0; imem.imem_rsp_err = 0;
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      chk("rst_req_valid", 32'(imem.imem_req_valid), 32'h0);
      chk("rst_req_addr", imem.imem_req_addr, 32'h0);
      chk("rst_if_id_pc", if_id_pc, 32'h0);
      check_ifid();
      rst_n = 1;
   endtask

   // ------------------------------------------------------ vector table
   typedef struct {
      bit          ps, rdy, rsp;
      bit          exp_rv;
      logic [31:0] exp_addr;
      bit          exp_v;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tv[5];
   logic [31:0] squash0;

   initial begin
      tv[0] = '{ps:0, rdy:1, rsp:0, exp_rv:1, exp_addr:32'h0, exp_v:0, exp_pc:32'h0};
      tv[1] = '{ps:0, rdy:1, rsp:1, exp_rv:1, exp_addr:32'h4, exp_v:1, exp_pc:32'h0};
      tv[2] = '{ps:0, rdy:1, rsp:1, exp_rv:1, exp_addr:32'h8, exp_v:1, exp_pc:32'h4};
      tv[3] = '{ps:1, rdy:1, rsp:1, exp_rv:0, exp_addr:32'hC, exp_v:1, exp_pc:32'h8};
      tv[4] = '{ps:1, rdy:1, rsp:0, exp_rv:0, exp_addr:32'hC, exp_v:0, exp_pc:32'h0};

      imem.imem_req_ready = 0; imem.imem_rsp_valid = 0;
      imem.imem_rsp_data = '0; imem.imem_rsp_err = 0;
      do_reset();

      // back-to-back issue, response one cycle after accept
      for (int i = 0; i < 5; i++) begin
         idle(tv[i].ps, 0, tv[i].rdy, tv[i].rsp, 0);
         chk("tv_req_valid", 32'(s_rv), 32'(tv[i].exp_rv));
         chk("tv_req_addr", s_addr, tv[i].exp_addr);
         chk("tv_if_id_valid", 32'(if_id_valid), 32'(tv[i].exp_v));
         if (tv[i].exp_v) begin
            chk("tv_if_id_pc", if_id_pc, tv[i].exp_pc);
            chk("tv_if_id_instr", if_id_instr, f_instr(tv[i].exp_pc));
         end
      end

      // request held while not ready, even across a pc_stall
      do_reset();
      for (int k = 0; k < 4; k++) begin
         idle(k == 2, 0, 0, 0, 0);
         chk("hold_req_valid", 32'(s_rv), 32'h1);
         chk("hold_req_addr", s_addr, 32'h0);
      end
      idle(0, 0, 1, 0, 0);
      idle(1, 0, 0, 0, 0);
      chk("hold_next_addr", s_addr, 32'h4);
      idle(1, 0, 0, 1, 0);
      chk("hold_rsp_pc", if_id_pc, 32'h0);

      // redirect with two outstanding requests
      redirect(32'h10, 0);
      idle(0, 0, 1, 0, 0);
      chk("br_addr10", s_addr, 32'h10);
      idle(0, 0, 1, 0, 0);
      chk("br_addr14", s_addr, 32'h14);
`ifdef FETCH_PERF_CNT_EN
      squash0 = perf_squash_cnt;
`else
      squash0 = 0;
`endif
      redirect(32'h103, 0);
      idle(0, 0, 0, 1, 0);
      chk("br_new_addr", s_addr, 32'h100);
      chk("br_no_credit", 32'(s_rv), 32'h0);
      chk("br_drop1_valid", 32'(if_id_valid), 32'h0);
      idle(0, 0, 1, 1, 0);
      chk("br_drop2_valid", 32'(if_id_valid), 32'h0);
      idle(1, 0, 0, 1, 0);
      chk("br_tgt_valid", 32'(if_id_valid), 32'h1);
      chk("br_tgt_pc", if_id_pc, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      chk("br_squash2", perf_squash_cnt - squash0, 32'h2);
`endif

      // redirect in the same cycle as a live response
      redirect(32'h10, 0);
      idle(0, 0, 1, 0, 0);
      idle(0, 0, 1, 0, 0);
      idle(1, 0, 0, 1, 0);
      chk("brrsp_first_pc", if_id_pc, 32'h10);
      redirect(32'h200, 1);
      chk("brrsp_discard", 32'(if_id_valid), 32'h0);

      // IF/ID stall with a full queue, then drain in order
      idle(0, 0, 1, 0, 0);
      idle(0, 0, 1, 1, 0);
      chk("stall_pre_pc", if_id_pc, 32'h200);
      for (int k = 0; k < 3; k++) begin
         idle(0, 1, 1, k < 2, 0);
         chk("stall_pc", if_id_pc, 32'h200);
         chk("stall_instr", if_id_instr, f_instr(32'h200));
      end
      chk("stall_full_rv", 32'(s_rv), 32'h0);
      idle(1, 0, 0, 0, 0);
      chk("drain_pc1", if_id_pc, 32'h204);
      idle(1, 0, 0, 0, 0);
      chk("drain_pc2", if_id_pc, 32'h208);

      // access fault
      redirect(32'h20, 0);
      idle(0, 0, 1, 0, 0);
      idle(1, 0, 0, 1, 1);
      chk("err_fault", 32'(if_id_fault), 32'h1);
      chk("err_instr", if_id_instr, 32'h0000_0013);
      chk("err_pc", if_id_pc, 32'h20);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 10) == 0,
              ($urandom % 12) == 0, $urandom, ($urandom % 3) != 0,
              ($urandom % 2) == 0, ($urandom % 8) == 0);
      end

      // reset while requests are outstanding
      idle(0, 0, 1, 0, 0);
      idle(0, 0, 1, 0, 0);
      do_reset();
      idle(0, 0, 1, 0, 0);
      idle(1, 0, 0, 1, 0);
      chk("post_rst_pc", if_id_pc, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
